// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ core: RAM operation encodings, FSM states, word geometry.
// The HALT state exists only when SUBLEQ_HALT_EN is defined.
package subleq_pkg;

    localparam int unsigned WORD_BYTES = 8;
    localparam logic [63:0] PC_STEP_B  = 64'(WORD_BYTES);
    localparam logic [63:0] PC_STEP_C  = 64'(2 * WORD_BYTES);
    localparam logic [63:0] PC_STEP_IN = 64'(3 * WORD_BYTES);

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } mem_op_e;

    typedef enum logic [2:0] {
        S_FA = 3'd0,
        S_FB = 3'd1,
        S_FC = 3'd2,
        S_LA = 3'd3,
        S_LB = 3'd4,
`ifdef SUBLEQ_HALT_EN
        S_EX = 3'd5,
        S_HALT = 3'd6
`else
        S_EX = 3'd5
`endif
    } state_e;

endpackage

// File: rtl/subleq_core.sv
// 64-bit SUBLEQ core: six-cycle fetch/load/execute FSM mastering a single-port word RAM.
// Define SUBLEQ_HALT_EN to stop the core on a taken branch to HALT_ADDR.
module subleq_core
    import subleq_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
`ifdef SUBLEQ_HALT_EN
    ,
    parameter logic [63:0] HALT_ADDR = {64{1'b1}}
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] mem_data,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_write_bytes,
    output logic [1:0]  mem_op
);

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] c_q, c_d;
    logic [63:0] va_q, va_d;
    mem_op_e     op;

    logic [63:0] diff;
    logic        taken;

    // Wrapped difference; the branch tests the wrapped value, overflow is ignored.
    assign diff  = mem_data - va_q;
    assign taken = (diff == 64'h0) || diff[63];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FA;
            pc_q    <= RESET_PC;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            va_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            va_q    <= va_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        a_d             = a_q;
        b_d             = b_q;
        c_d             = c_q;
        va_d            = va_q;
        op              = OP_IDLE;
        mem_addr        = '0;
        mem_write_bytes = '0;

        unique case (state_q)
            S_FA: begin
                op       = OP_READ;
                mem_addr = pc_q;
                state_d  = S_FB;
            end
            S_FB: begin
                a_d      = mem_data;
                op       = OP_READ;
                mem_addr = pc_q + PC_STEP_B;
                state_d  = S_FC;
            end
            S_FC: begin
                b_d      = mem_data;
                op       = OP_READ;
                mem_addr = pc_q + PC_STEP_C;
                state_d  = S_LA;
            end
            S_LA: begin
                c_d      = mem_data;
                op       = OP_READ;
                mem_addr = a_q;
                state_d  = S_LB;
            end
            S_LB: begin
                va_d     = mem_data;
                op       = OP_READ;
                mem_addr = b_q;
                state_d  = S_EX;
            end
            S_EX: begin
                op              = OP_WRITE;
                mem_addr        = b_q;
                mem_write_bytes = diff;
                pc_d            = taken ? c_q : pc_q + PC_STEP_IN;
                state_d         = S_FA;
`ifdef SUBLEQ_HALT_EN
                if (taken && (c_q == HALT_ADDR)) begin
                    state_d = S_HALT;
                end
`endif
            end
`ifdef SUBLEQ_HALT_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_FA;
            end
        endcase

        // Reset overrides the bus so the RAM never sees a stray request.
        if (reset) begin
            op              = OP_IDLE;
            mem_addr        = '0;
            mem_write_bytes = '0;
        end
    end

    assign mem_op = op;

endmodule

// File: tb/tb_subleq_core.sv
// Scoreboard bench for subleq_core: expected bus transactions are queued per program,
// and a negedge monitor compares every cycle's bus request against the queue head.
module tb_subleq_core;

    typedef struct packed {
        logic [1:0]  op;
        logic [63:0] addr;
        logic [63:0] data;
    } txn_t;

    localparam logic [1:0]  RD   = 2'b01;
    localparam logic [1:0]  WR   = 2'b10;
    localparam logic [63:0] ONES = {64{1'b1}};
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    logic        clk;
    logic        reset;
    logic [63:0] mem_data;
    logic [63:0] mem_addr;
    logic [63:0] mem_write_bytes;
    logic [1:0]  mem_op;

    logic [63:0] mem [0:63];
    txn_t        sb_q[$];
    int          n_checks;
    int          n_fail;
    string       cur_case;

    subleq_core dut (
        .clk             (clk),
        .reset           (reset),
        .mem_data        (mem_data),
        .mem_addr        (mem_addr),
        .mem_write_bytes (mem_write_bytes),
        .mem_op          (mem_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: read data appears the cycle after the request; writes commit at the edge.
    always @(posedge clk) begin
        if (mem_op == RD) mem_data <= mem[mem_addr[8:3]];
        if (mem_op == WR) mem[mem_addr[8:3]] <= mem_write_bytes;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h expected %h", cur_case, name, act, exp);
        end
    endtask

    // Non-pipelined core: while transactions are pending, every cycle must match the next one.
    always @(negedge clk) begin
        if (!reset && sb_q.size() > 0) begin
            txn_t e;
            e = sb_q.pop_front();
            check("op", 64'(mem_op), 64'(e.op));
            check("addr", mem_addr, e.addr);
            check("wdata", mem_write_bytes, e.data);
        end
    end

    task automatic push(input logic [1:0] op, input logic [63:0] addr, input logic [63:0] data);
        txn_t t;
        t.op   = op;
        t.addr = addr;
        t.data = data;
        sb_q.push_back(t);
    endtask

    // One instruction at PC 0 with operands A/B/C; expected write value and next PC are hand-computed.
    task automatic run_case(input string name, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic [63:0] va, input logic [63:0] vb,
                            input logic [63:0] exp_d, input logic [63:0] exp_pc,
                            input bit expect_halt);
        cur_case = name;
        reset = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = a;
        mem[1] = b;
        mem[2] = c;
        mem[a[8:3]] = va;
        mem[b[8:3]] = vb;
        push(RD, 64'd0, '0);
        push(RD, 64'd8, '0);
        push(RD, 64'd16, '0);
        push(RD, a, '0);
        push(RD, b, '0);
        push(WR, b, exp_d);
        if (!expect_halt) push(RD, exp_pc, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_op", 64'(mem_op), 64'd0);
        check("rst_addr", mem_addr, 64'd0);
        check("rst_data", mem_write_bytes, 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        if (expect_halt) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("halt_op", 64'(mem_op), 64'd0);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        bit halt_on;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        mem_data = '0;
`ifdef SUBLEQ_HALT_EN
        halt_on = 1'b1;
`else
        halt_on = 1'b0;
`endif
        run_case("pos",     64'd64, 64'd72, 64'd200, 64'd5, 64'd8, 64'd3,       64'd24,  1'b0);
        run_case("zero",    64'd64, 64'd72, 64'd200, 64'd8, 64'd8, 64'd0,       64'd200, 1'b0);
        run_case("neg",     64'd64, 64'd72, 64'd200, 64'd9, 64'd8, ONES,        64'd200, 1'b0);
        run_case("ovf",     64'd64, 64'd72, 64'd200, 64'd1, MSB,   ~MSB,        64'd24,  1'b0);
        run_case("a_eq_b",  64'd72, 64'd72, 64'd200, 64'd12, 64'd12, 64'd0,     64'd200, 1'b0);
        run_case("halt_tg", 64'd64, 64'd72, ONES,    64'd8, 64'd8, 64'd0,       ONES,    halt_on);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
